// File: rtl/sc_config_pkg.sv
// Shared definitions for the scan-converter config shadow stage.
//   - Register index map of the shadowed config words.
//   - Bit positions of the CPU-visible status word.
//   - FSM state type of the shadow controller.
//   - Helper that packs the status word from its fields.
package sc_config_pkg;

    localparam int SC_NUM_CFG_REGS = 13;

    // Word index of each shadowed config register inside the flat vector.
    typedef enum int unsigned {
        REG_H_ACTIVE  = 0,
        REG_V_ACTIVE  = 1,
        REG_H_TOTAL   = 2,
        REG_V_TOTAL   = 3,
        REG_H_SYNC    = 4,
        REG_V_SYNC    = 5,
        REG_H_OFFSET  = 6,
        REG_V_OFFSET  = 7,
        REG_SCALE_X   = 8,
        REG_SCALE_Y   = 9,
        REG_LINE_MODE = 10,
        REG_MASK      = 11,
        REG_MISC      = 12
    } sc_reg_idx_t;

    // Status word layout.
    localparam int STAT_CNT_LSB  = 0;
    localparam int STAT_CNT_W    = 8;
    localparam int STAT_PEND_BIT = 8;
    localparam int STAT_TO_BIT   = 9;
    localparam int STAT_OVR_BIT  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } shadow_state_t;

    function automatic logic [31:0] pack_status(
        input logic [7:0] cnt,
        input logic       pend,
        input logic       to,
        input logic       ovr
    );
        logic [31:0] s;
        s = '0;
        s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        s[STAT_PEND_BIT]              = pend;
        s[STAT_TO_BIT]                = to;
        s[STAT_OVR_BIT]               = ovr;
        return s;
    endfunction

endpackage

// File: rtl/sc_config_shadow_if.sv
// Bus between the config register bank (master) and the shadow stage (slave).
//
// Signalling: there is no valid/ready pair. upd_req_i and force_i are levels
// owned by the register bank; the shadow stage acts only on their rising
// edges, so the bank may hold them high for any number of cycles. vs_i is the
// raw vertical sync; its leading edge is the frame boundary. cfg_staged_i may
// change at any time and is sampled only in the apply cycle.
//
// Signals:
//   cfg_staged_i  NUM_REGS*32  staged config words, word k at [32k+31:32k]
//   upd_req_i     1            update request level
//   force_i       1            immediate-apply request level
//   vs_i          1            vertical sync
//   cfg_active_o  NUM_REGS*32  active config words
//   upd_pending_o 1            request accepted but not yet applied
//   upd_done_o    1            one-cycle pulse per apply
//   status_o      32           status word for CPU readback
//   state_dbg     2            current controller state (debug)
interface sc_config_shadow_if #(
    parameter int NUM_REGS = sc_config_pkg::SC_NUM_CFG_REGS
) ();
    import sc_config_pkg::*;

    logic [NUM_REGS*32-1:0] cfg_staged_i;
    logic                   upd_req_i;
    logic                   force_i;
    logic                   vs_i;
    logic [NUM_REGS*32-1:0] cfg_active_o;
    logic                   upd_pending_o;
    logic                   upd_done_o;
    logic [31:0]            status_o;
    shadow_state_t          state_dbg;

    modport master (
        output cfg_staged_i, upd_req_i, force_i, vs_i,
        input  cfg_active_o, upd_pending_o, upd_done_o, status_o, state_dbg
    );

    modport slave (
        input  cfg_staged_i, upd_req_i, force_i, vs_i,
        output cfg_active_o, upd_pending_o, upd_done_o, status_o, state_dbg
    );

endinterface

// File: rtl/sc_edge_det.sv
// Synchronous rising-edge detector for one level input.
// The input is first normalised to active-high using POL, then compared with
// its one-flop history. The history resets to 0, so an input already active
// when reset is released reports an edge in the first cycle.
//
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   sig    level input (active level given by POL)
//   rise   high in the cycle where sig first shows its active level
module sc_edge_det #(
    parameter logic POL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig,
    output logic rise
);

    logic cur;
    logic prev;

    assign cur = (sig == POL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev <= 1'b0;
        end else begin
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;

endmodule

// File: rtl/sc_config_shadow.sv
// Frame-synchronous shadow stage for the scan-converter config words.
// Staged words are copied to the active outputs only at a vsync leading edge
// (or on a forced apply / timeout), so downstream blocks never see geometry
// change mid-frame.
//
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    sc_config_shadow_if.slave (staged words, request/force/vsync in;
//          active words, pending, done pulse, status word, debug state out)
//
// Parameters:
//   NUM_REGS        number of 32-bit words shadowed
//   TIMEOUT_CYCLES  ARMED cycles before a forced apply; 0 disables
//   VS_POL          active level of vs_i
module sc_config_shadow
    import sc_config_pkg::*;
#(
    parameter int          NUM_REGS       = SC_NUM_CFG_REGS,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter logic        VS_POL         = 1'b1
) (
    input logic               clk_i,
    input logic               rst_i,
    sc_config_shadow_if.slave bus
);

    localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
    // Wraps to all-ones when the timeout is disabled; gated by TO_EN.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

    shadow_state_t state;
    shadow_state_t state_next;

    logic upd_rise;
    logic force_rise;
    logic vs_rise;

    logic [31:0] to_cnt;
    logic        to_hit;

    logic set_to;
    logic set_ovr;
    logic clr_sticky;
    logic arm_load;

    logic [NUM_REGS*32-1:0] cfg_active;
    logic [7:0]             apply_cnt;
    logic                   to_flag;
    logic                   ovr_flag;
    logic                   done_q;
    logic                   pending;

    sc_edge_det #(.POL(1'b1)) u_upd_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sig   (bus.upd_req_i),
        .rise  (upd_rise)
    );

    sc_edge_det #(.POL(1'b1)) u_force_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sig   (bus.force_i),
        .rise  (force_rise)
    );

    sc_edge_det #(.POL(VS_POL)) u_vs_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sig   (bus.vs_i),
        .rise  (vs_rise)
    );

    assign to_hit = TO_EN && (to_cnt == TO_LAST);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        set_to     = 1'b0;
        set_ovr    = 1'b0;
        clr_sticky = 1'b0;
        arm_load   = 1'b0;

        case (state)
            IDLE: begin
                if (upd_rise) begin
                    clr_sticky = 1'b1;
                    arm_load   = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                // A repeated request is absorbed; the armed one still covers it.
                if (upd_rise) begin
                    set_ovr = 1'b1;
                end
                // Frame boundary beats a coincident timeout.
                if (vs_rise) begin
                    state_next = APPLY;
                end else if (to_hit) begin
                    state_next = APPLY;
                    set_to     = 1'b1;
                end
            end
            APPLY: begin
                // One-deep request memory: a request arriving during the apply
                // cycle re-arms straight away.
                if (upd_rise) begin
                    arm_load   = 1'b1;
                    state_next = ARMED;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Force overrides everything; the apply it triggers satisfies any
        // outstanding request.
        if (force_rise) begin
            state_next = APPLY;
            set_to     = 1'b0;
            arm_load   = 1'b0;
        end
    end

    // Timeout counter: restarts on entry to ARMED, runs while ARMED.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (arm_load) begin
            to_cnt <= '0;
        end else if (TO_EN && (state == ARMED)) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    // Active words, apply counter, done pulse and sticky flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_active <= '0;
            apply_cnt  <= '0;
            to_flag    <= 1'b0;
            ovr_flag   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state == APPLY);
            if (state == APPLY) begin
                cfg_active <= bus.cfg_staged_i;
                apply_cnt  <= apply_cnt + 8'd1;
            end
            if (clr_sticky) begin
                to_flag  <= 1'b0;
                ovr_flag <= 1'b0;
            end else begin
                if (set_to) begin
                    to_flag <= 1'b1;
                end
                if (set_ovr) begin
                    ovr_flag <= 1'b1;
                end
            end
        end
    end

    assign pending = (state == ARMED);

    assign bus.cfg_active_o  = cfg_active;
    assign bus.upd_pending_o = pending;
    assign bus.upd_done_o    = done_q;
    assign bus.status_o      = pack_status(apply_cnt, pending, to_flag, ovr_flag);
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_sc_config_shadow.sv
module tb_sc_config_shadow;
    import sc_config_pkg::*;

    localparam int NR = 13;
    localparam int TO = 100;

    // ---------------- clock / reset / drive ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic frc = 1'b0;
    logic vs  = 1'b0;
    logic [NR*32-1:0] staged = '0;

    always #5 clk = ~clk;

    sc_config_shadow_if #(.NUM_REGS(NR)) bus ();

    assign bus.cfg_staged_i = staged;
    assign bus.upd_req_i    = req;
    assign bus.force_i      = frc;
    assign bus.vs_i         = vs;

    sc_config_shadow #(
        .NUM_REGS       (NR),
        .TIMEOUT_CYCLES (TO),
        .VS_POL         (1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    // Described in terms of "a request is waiting", "an apply happens next
    // cycle" and how long the request has waited.
    logic [NR*32-1:0] m_active;
    int  m_count;
    bit  m_waiting, m_apply_next, m_done, m_to, m_ovr;
    int  m_age;
    bit  p_req, p_frc, p_vs;

    function automatic void model_reset();
        m_active     = '0;
        m_count      = 0;
        m_waiting    = 0;
        m_apply_next = 0;
        m_done       = 0;
        m_to         = 0;
        m_ovr        = 0;
        m_age        = 0;
        p_req        = 0;
        p_frc        = 0;
        p_vs         = 0;
    endfunction

    function automatic void model_step();
        bit re, fe, ve, was_wait, was_apply;
        re = req & ~p_req;
        fe = frc & ~p_frc;
        ve = vs & ~p_vs;
        p_req = req;
        p_frc = frc;
        p_vs  = vs;
        was_wait  = m_waiting;
        was_apply = m_apply_next;
        m_done = was_apply;
        if (was_apply) begin
            m_active = staged;
            m_count  = (m_count + 1) % 256;
        end
        m_apply_next = 0;
        if (was_wait && re) m_ovr = 1;
        if (!was_wait && !was_apply && re) begin
            m_to  = 0;
            m_ovr = 0;
        end
        if (fe) begin
            m_waiting    = 0;
            m_apply_next = 1;
        end else if (was_wait) begin
            if (ve) begin
                m_waiting    = 0;
                m_apply_next = 1;
            end else if (m_age == TO - 1) begin
                m_waiting    = 0;
                m_apply_next = 1;
                m_to         = 1;
            end else begin
                m_age++;
            end
        end else if (re) begin
            m_waiting = 1;
            m_age     = 0;
        end
    endfunction

    function automatic logic [31:0] model_status();
        return {21'b0, m_ovr, m_to, m_waiting, 8'(m_count)};
    endfunction

    // One clock: model follows the inputs sampled at the edge; outputs are
    // read 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.cfg_active_o !== '0) $display("FAIL reset_active: got %h want 0", bus.cfg_active_o);
        else n_pass++;
        n_checks++;
        if (bus.status_o !== 32'h0) $display("FAIL reset_status: got %h want 0", bus.status_o);
        else n_pass++;
        n_checks++;
        if (bus.upd_pending_o !== 1'b0 || bus.upd_done_o !== 1'b0)
            $display("FAIL reset_pend_done: got %b%b want 00", bus.upd_pending_o, bus.upd_done_o);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_req_vsync();
        for (int k = 0; k < NR; k++) staged[k*32 +: 32] = $urandom();
        staged[31:0] = 32'h12345678;
        req = 1'b1;
        tick();
        req = 1'b0;
        n_checks++;
        if (bus.upd_pending_o !== 1'b1) $display("FAIL rv_pending_armed: got %b want 1", bus.upd_pending_o);
        else n_pass++;
        repeat (49) tick();
        vs = 1'b1;
        tick();
        n_checks++;
        if (bus.cfg_active_o[31:0] !== 32'h0 || bus.upd_done_o !== 1'b0)
            $display("FAIL rv_early: word0 %h done %b want 0 0", bus.cfg_active_o[31:0], bus.upd_done_o);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.cfg_active_o[31:0] !== 32'h12345678)
            $display("FAIL rv_word0: got %h want 12345678", bus.cfg_active_o[31:0]);
        else n_pass++;
        n_checks++;
        if (bus.upd_done_o !== 1'b1) $display("FAIL rv_done: got %b want 1", bus.upd_done_o);
        else n_pass++;
        n_checks++;
        if (bus.status_o[7:0] !== 8'd1) $display("FAIL rv_count: got %0d want 1", bus.status_o[7:0]);
        else n_pass++;
        n_checks++;
        if (bus.upd_pending_o !== 1'b0) $display("FAIL rv_pending_after: got %b want 0", bus.upd_pending_o);
        else n_pass++;
        vs = 1'b0;
        tick();
        n_checks++;
        if (bus.upd_done_o !== 1'b0) $display("FAIL rv_done_pulse: got %b want 0", bus.upd_done_o);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [7:0] cnt0;
        int k;
        bit seen;
        cnt0 = bus.status_o[7:0];
        for (int i = 0; i < NR; i++) staged[i*32 +: 32] = $urandom();
        req = 1'b1;
        tick();
        req = 1'b0;
        k = 0;
        seen = 0;
        while (!seen && k < 200) begin
            tick();
            k++;
            if (bus.upd_done_o === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || k != TO + 1) $display("FAIL to_latency: done after %0d cycles want %0d", k, TO + 1);
        else n_pass++;
        n_checks++;
        if (bus.status_o[9] !== 1'b1) $display("FAIL to_flag: got %b want 1", bus.status_o[9]);
        else n_pass++;
        n_checks++;
        if (bus.status_o[7:0] !== cnt0 + 8'd1) $display("FAIL to_count: got %0d want %0d", bus.status_o[7:0], cnt0 + 8'd1);
        else n_pass++;
        n_checks++;
        if (bus.cfg_active_o !== staged) $display("FAIL to_active: got %h want %h", bus.cfg_active_o, staged);
        else n_pass++;
    endtask

    task automatic test_staged_change();
        staged[3*32 +: 32] = 32'hA;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (5) tick();
        staged[3*32 +: 32] = 32'hB;
        repeat (3) tick();
        vs = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.cfg_active_o[3*32 +: 32] !== 32'hB)
            $display("FAIL staged_change_word3: got %h want b", bus.cfg_active_o[3*32 +: 32]);
        else n_pass++;
        vs = 1'b0;
        tick();
    endtask

    task automatic test_force_overrun();
        logic [7:0] cnt0;
        int ndone;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (3) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        n_checks++;
        if (bus.status_o[10] !== 1'b1 || bus.upd_pending_o !== 1'b1)
            $display("FAIL ovr_flag: ovr %b pend %b want 1 1", bus.status_o[10], bus.upd_pending_o);
        else n_pass++;
        cnt0 = bus.status_o[7:0];
        frc = 1'b1;
        tick();
        frc = 1'b0;
        tick();
        n_checks++;
        if (bus.upd_done_o !== 1'b1 || bus.status_o[7:0] !== cnt0 + 8'd1)
            $display("FAIL force_apply: done %b count %0d want 1 %0d", bus.upd_done_o, bus.status_o[7:0], cnt0 + 8'd1);
        else n_pass++;
        n_checks++;
        if (bus.upd_pending_o !== 1'b0 || bus.state_dbg !== IDLE || bus.status_o[10] !== 1'b1)
            $display("FAIL force_idle: pend %b state %0d ovr %b want 0 0 1", bus.upd_pending_o, bus.state_dbg, bus.status_o[10]);
        else n_pass++;
        vs = 1'b1;
        ndone = 0;
        repeat (4) begin
            tick();
            if (bus.upd_done_o === 1'b1) ndone++;
        end
        vs = 1'b0;
        tick();
        n_checks++;
        if (ndone != 0 || bus.status_o[7:0] !== cnt0 + 8'd1)
            $display("FAIL force_no_repeat: extra applies %0d count %0d want 0 %0d", ndone, bus.status_o[7:0], cnt0 + 8'd1);
        else n_pass++;
    endtask

    task automatic test_vs_timeout_same();
        logic [7:0] cnt0;
        cnt0 = bus.status_o[7:0];
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (TO - 1) tick();
        vs = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.upd_done_o !== 1'b1 || bus.status_o[7:0] !== cnt0 + 8'd1)
            $display("FAIL same_apply: done %b count %0d want 1 %0d", bus.upd_done_o, bus.status_o[7:0], cnt0 + 8'd1);
        else n_pass++;
        n_checks++;
        if (bus.status_o[9] !== 1'b0) $display("FAIL same_to_flag: got %b want 0", bus.status_o[9]);
        else n_pass++;
        vs = 1'b0;
        tick();
    endtask

    task automatic test_req_during_apply();
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (2) tick();
        vs = 1'b1;
        tick();
        req = 1'b1;
        tick();
        n_checks++;
        if (bus.upd_done_o !== 1'b1 || bus.upd_pending_o !== 1'b1 || bus.state_dbg !== ARMED)
            $display("FAIL rearm: done %b pend %b state %0d want 1 1 1", bus.upd_done_o, bus.upd_pending_o, bus.state_dbg);
        else n_pass++;
        n_checks++;
        if (bus.status_o[10] !== 1'b0 || bus.status_o[8] !== 1'b1)
            $display("FAIL rearm_status: ovr %b pend %b want 0 1", bus.status_o[10], bus.status_o[8]);
        else n_pass++;
        req = 1'b0;
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.upd_done_o !== 1'b1 || bus.upd_pending_o !== 1'b0)
            $display("FAIL rearm_apply: done %b pend %b want 1 0", bus.upd_done_o, bus.upd_pending_o);
        else n_pass++;
        vs = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int ndone;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        ndone = 0;
        for (int i = 0; i < 256; i++) begin
            frc = 1'b1;
            tick();
            if (bus.upd_done_o === 1'b1) ndone++;
            frc = 1'b0;
            tick();
            if (bus.upd_done_o === 1'b1) ndone++;
            if (i == 254) begin
                n_checks++;
                if (bus.status_o[7:0] !== 8'd255) $display("FAIL wrap_255: got %0d want 255", bus.status_o[7:0]);
                else n_pass++;
            end
        end
        tick();
        if (bus.upd_done_o === 1'b1) ndone++;
        n_checks++;
        if (bus.status_o[7:0] !== 8'd0 || ndone != 256)
            $display("FAIL wrap_0: count %0d applies %0d want 0 256", bus.status_o[7:0], ndone);
        else n_pass++;
    endtask

    task automatic test_reset_mid_armed();
        int ndone;
        for (int k = 0; k < NR; k++) staged[k*32 +: 32] = $urandom();
        staged[0] = 1'b1;
        frc = 1'b1;
        tick();
        frc = 1'b0;
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.cfg_active_o !== '0 || bus.status_o !== 32'h0)
            $display("FAIL midrst_outputs: active %h status %h want 0 0", bus.cfg_active_o, bus.status_o);
        else n_pass++;
        n_checks++;
        if (bus.upd_pending_o !== 1'b0 || bus.upd_done_o !== 1'b0)
            $display("FAIL midrst_pend_done: got %b%b want 00", bus.upd_pending_o, bus.upd_done_o);
        else n_pass++;
        vs = 1'b1;
        ndone = 0;
        repeat (4) begin
            tick();
            if (bus.upd_done_o === 1'b1) ndone++;
        end
        vs = 1'b0;
        tick();
        n_checks++;
        if (ndone != 0 || bus.cfg_active_o !== '0)
            $display("FAIL midrst_no_apply: applies %0d active %h want 0 0", ndone, bus.cfg_active_o);
        else n_pass++;
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) req = ~req;
            if ($urandom_range(0, 79) == 0) frc = ~frc;
            if ($urandom_range(0, 39) == 0) vs = ~vs;
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, NR - 1);
                staged[k*32 +: 32] = $urandom();
            end
            rst = ($urandom_range(0, 1499) == 0);
            tick();
            n_checks++;
            if (bus.cfg_active_o !== m_active)
                $display("FAIL rnd_active c=%0d: got %h want %h", c, bus.cfg_active_o, m_active);
            else n_pass++;
            n_checks++;
            if (bus.upd_done_o !== m_done)
                $display("FAIL rnd_done c=%0d: got %b want %b", c, bus.upd_done_o, m_done);
            else n_pass++;
            n_checks++;
            if (bus.status_o !== model_status())
                $display("FAIL rnd_status c=%0d: got %h want %h", c, bus.status_o, model_status());
            else n_pass++;
            n_checks++;
            if (bus.upd_pending_o !== m_waiting)
                $display("FAIL rnd_pending c=%0d: got %b want %b", c, bus.upd_pending_o, m_waiting);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_req_vsync();
        test_timeout();
        test_staged_change();
        test_force_overrun();
        test_vs_timeout_same();
        test_req_during_apply();
        test_wrap();
        test_reset_mid_armed();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
